// File: rtl/mdu_seq_pkg.sv
// mdu_seq_pkg: shared op and state encodings for the sequential multiply/divide unit
package mdu_seq_pkg;
    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_DIVU  = 2'b01;
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;
endpackage

// File: rtl/mdu_ctr.sv
// mdu_ctr: iteration counter cleared on issue, counting while an op runs
// Ports: clk/rst (async, active-high), clr loads zero, en advances,
// tc flags the last iteration (count == wide-1).
module mdu_ctr #(
    parameter int wide = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int CW = $clog2(wide) + 1;
    logic [CW-1:0] cnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else if (clr)
            cnt_q <= '0;
        else if (en)
            cnt_q <= cnt_q + CW'(1);
    end
    assign tc = cnt_q == CW'(wide - 1);
endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: iterative MULTU/DIVU unit, one bit per clock, producing HI/LO
// Ports: clk/rst (async, active-high); start/op/a/b issue an operation;
// busy while iterating; done pulses for one cycle when hi/lo load.
// MULTU: {hi,lo} = a*b.  DIVU: hi = a%b, lo = a/b; b==0 gives hi=a, lo=all ones.
module mdu_seq
    import mdu_seq_pkg::*;
#(
    parameter int wide = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [wide-1:0] a,
    input  logic [wide-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [wide-1:0] hi,
    output logic [wide-1:0] lo
);
    state_t            state_q;
    logic              busy_q, done_q;
    logic [wide-1:0]   hi_q, lo_q;
    // MUL: {partial, multiplier}; DIV: lower half is the dividend shifting into the quotient
    logic [2*wide-1:0] acc_q, acc_d;
    logic [wide-1:0]   rem_q, rem_d;
    // multiplicand for MUL, divisor for DIV
    logic [wide-1:0]   opd_q;
    logic [wide:0]     sum, sh, trial;
    logic              accept, running, tc;

    assign accept  = start && (state_q == IDLE || state_q == DONE) && (op == OP_MULTU || op == OP_DIVU);
    assign running = state_q == MUL || state_q == DIV;

    mdu_ctr #(.wide(wide)) u_ctr (
        .clk(clk),
        .rst(rst),
        .clr(accept),
        .en (running),
        .tc (tc)
    );

    always_comb begin
        sum   = {1'b0, acc_q[2*wide-1:wide]} + {1'b0, (acc_q[0] ? opd_q : '0)};
        sh    = {rem_q, acc_q[wide-1]};
        trial = sh - {1'b0, opd_q};
        // sh < 2*divisor, so a non-negative trial always fits in wide bits
        rem_d = trial[wide] ? sh[wide-1:0] : trial[wide-1:0];
        acc_d = state_q == MUL ? {sum, acc_q[wide-1:1]}
                               : {acc_q[2*wide-1:wide], acc_q[wide-2:0], ~trial[wide]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            opd_q   <= '0;
        end else if (accept) begin
            acc_q   <= {{wide{1'b0}}, (op == OP_MULTU ? b : a)};
            opd_q   <= op == OP_MULTU ? a : b;
            rem_q   <= '0;
            state_q <= op == OP_MULTU ? MUL : DIV;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else if (state_q == DIV && opd_q == '0) begin
            // divide by zero resolves after a single busy cycle
            hi_q    <= acc_q[wide-1:0];
            lo_q    <= '1;
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
        end else if (running) begin
            acc_q <= acc_d;
            rem_q <= rem_d;
            if (tc) begin
                hi_q    <= state_q == MUL ? acc_d[2*wide-1:wide] : rem_d;
                lo_q    <= acc_d[wide-1:0];
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
            end
        end else if (state_q == DONE) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule
